pdm_modulator: RTL and testbench
================================

Name: pdm_modulator

Overview:
- Transmit-side counterpart of the filter & decimator: converts a stream of unsigned 8-bit PCM samples into a 1-bit pulse-density (first-order sigma-delta) bitstream, one bit per clk.
- Its 1-bit output feeds the filter's 1-bit data input directly, enabling closed-loop self-test of the receive chain.
- Samples are queued in a small FIFO. One sample is consumed every OSR clocks.

Parameters:
- SAMPLE_W, default 8: sample width in bits. Samples are unsigned offset-binary; midscale is 2^(SAMPLE_W-1).
- OSR, default 64: clocks (output bits) per input sample. Must be >= 2.
- DEPTH, default 4: sample FIFO depth. Must be a power of 2, >= 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  modulator run enable.
- sample_in  in  SAMPLE_W  PCM sample.
- sample_valid  in  1  sample_in is valid.
- sample_ready  out  1  FIFO can accept a sample (count < DEPTH).
- data  out  1  registered PDM bitstream.
- underrun  out  1  one-cycle pulse: frame boundary reached with FIFO empty.
- fill_level  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, takes effect immediately with no clock edge):
  - data=0, underrun=0, fill_level=0, sample_ready=1.
  - Internal state: acc=0, phase=0, cur=midscale (8'h80), FIFO pointers cleared.
- FIFO:
  - Push occurs when sample_valid && sample_ready.
  - sample_ready is driven combinationally from the count register: 1 iff count < DEPTH.
  - No bypass: a pushed sample is visible to the pop logic from the next cycle.
  - Push and pop in the same cycle: count unchanged.
  - Push while full cannot occur (ready=0); the sender holds.
  - FIFO writes are accepted regardless of en.
- Modulator, every clk with en=1:
  - sum = {0,acc} + {0,cur}, SAMPLE_W+1 bits.
  - data <= sum[SAMPLE_W].
  - acc <= sum[SAMPLE_W-1:0].
  - phase <= (phase==OSR-1) ? 0 : phase+1.
  - Resulting ones density = cur / 2^SAMPLE_W.
- Frame boundary (en=1 and phase==OSR-1):
  - If FIFO is non-empty: pop the head into cur. The new cur is used from the next cycle; acc is not cleared.
  - If FIFO is empty: cur is retained and underrun=1 for exactly that cycle.
  - A push in the same cycle as an empty-FIFO boundary still underruns; the pushed sample is consumed at the next boundary.
- en=0:
  - acc, phase, cur and data hold their values.
  - underrun=0.
  - No pop occurs.
- underrun is 0 in every other cycle.
- Latency: a sample pushed into an empty FIFO begins affecting data at the bit emitted 2 cycles after the next boundary cycle.

Test Plan:
- Silence after reset: reset, en=1, no pushes -> data = 0,1,0,1,… starting at the first edge; underrun pulses on cycles 63, 127, 191 after en rises; fill_level stays 0.
- Tone change: push 8'h40 during frame 0 -> frame 0 alternates (32 ones), ending with acc=0. Frame 1 is pattern 0,0,0,1 repeating (16 ones per 64 bits); no underrun at the end of frame 0; underrun at the end of frame 1; frame 2 repeats 8'h40.
- Extremes: queue 8'h00 -> frame of all zeros. Queue 8'hFF with OSR=256 and acc=0 at frame start -> exactly 255 ones and 1 zero (the first bit).
- Backpressure: en=0, present 5 samples back-to-back -> 4 accepted, sample_ready=0 and fill_level=4 after the 4th; 5th is accepted one cycle after the first pop with en=1.
- Enable hold: drop en at phase 20 for 10 cycles -> data and phase frozen, no underrun; the resumed bit sequence is identical to the uninterrupted run, shifted by 10 cycles.
- Async reset mid-frame: pull reset_n low at phase 30, between clock edges, with fill_level=3 -> data=0, fill_level=0, sample_ready=1 immediately; after release, output is the midscale alternating pattern.

Source files
------------

// File: rtl/pdm_modulator.sv
// First-order sigma-delta PDM modulator: unsigned PCM samples queued in a small FIFO,
// one sample consumed every OSR clocks, one output bit per clock.
module pdm_modulator #(
    parameter int unsigned SAMPLE_W = 8,
    parameter int unsigned OSR      = 64,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      en_i,
    input  logic [SAMPLE_W-1:0]       sample_in_i,
    input  logic                      sample_valid_i,
    output logic                      sample_ready_o,
    output logic                      data_o,
    output logic                      underrun_o,
    output logic [$clog2(DEPTH):0]    fill_level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = $clog2(OSR);

    localparam logic [PW-1:0]       PhaseLast = PW'(OSR - 1);
    localparam logic [AW:0]         DepthCnt  = (AW + 1)'(DEPTH);
    localparam logic [SAMPLE_W-1:0] Midscale  = {1'b1, {(SAMPLE_W - 1){1'b0}}};

    logic [SAMPLE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic [SAMPLE_W-1:0] acc_q, acc_d;
    logic [SAMPLE_W-1:0] cur_q, cur_d;
    logic [PW-1:0]       phase_q, phase_d;
    logic                data_q, data_d;

    logic                push, pop, boundary, empty;
    logic [SAMPLE_W:0]   sum;

    assign empty    = (count_q == '0);
    assign boundary = en_i && (phase_q == PhaseLast);
    assign pop      = boundary && !empty;
    assign push     = sample_valid_i && sample_ready_o;
    assign sum      = {1'b0, acc_q} + {1'b0, cur_q};

    assign sample_ready_o = (count_q < DepthCnt);
    assign fill_level_o   = count_q;
    assign data_o         = data_q;
    // Empty FIFO at a frame boundary: hold the current sample and flag it for this cycle only.
    assign underrun_o     = boundary && empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        acc_d    = acc_q;
        cur_d    = cur_q;
        phase_d  = phase_q;
        data_d   = data_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            cur_d    = mem_q[rd_ptr_q];
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase

        if (en_i) begin
            data_d  = sum[SAMPLE_W];
            acc_d   = sum[SAMPLE_W-1:0];
            phase_d = (phase_q == PhaseLast) ? '0 : phase_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            acc_q    <= '0;
            cur_q    <= Midscale;
            phase_q  <= '0;
            data_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            cur_q    <= cur_d;
            phase_q  <= phase_d;
            data_q   <= data_d;
        end
    end

    // Sample storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sample_in_i;
        end
    end

endmodule

// File: tb/tb_pdm_modulator.sv
// Self-checking bench for pdm_modulator: hand vectors, directed corner sequences and random
// traffic against a model that tracks the running integral of all samples applied.
module tb_pdm_modulator;

    localparam int unsigned W     = 8;
    localparam int unsigned OSR   = 64;
    localparam int unsigned DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         en;
    logic [W-1:0] sample_in;
    logic         sample_valid;
    logic         sample_ready;
    logic         data;
    logic         underrun;
    logic [2:0]   fill_level;

    int errors = 0;
    int checks = 0;

    // Model: bit n is the carry out of the running integral total = sum of applied samples.
    longint       m_total;
    int           m_cur;
    int           m_phase;
    int           m_data;
    int           m_q[$];

    typedef struct {
        logic       e;
        logic       v;
        logic [7:0] s;
        int         exp_data;
        int         exp_fill;
    } vec_t;

    vec_t vecs[8];

    pdm_modulator #(
        .SAMPLE_W (W),
        .OSR      (OSR),
        .DEPTH    (DEPTH)
    ) dut (
        .clk_i          (clk),
        .reset_ni       (reset_n),
        .en_i           (en),
        .sample_in_i    (sample_in),
        .sample_valid_i (sample_valid),
        .sample_ready_o (sample_ready),
        .data_o         (data),
        .underrun_o     (underrun),
        .fill_level_o   (fill_level)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_init();
        m_total = 0;
        m_cur   = 128;
        m_phase = 0;
        m_data  = 0;
        m_q.delete();
    endfunction

    // One clock: inputs applied, outputs compared at negedge, model advanced at posedge.
    task automatic cyc(input logic e, input logic v, input logic [7:0] s);
        bit     rdy;
        bit     bnd;
        longint old;
        en           = e;
        sample_valid = v;
        sample_in    = s;
        @(negedge clk);
        chk("ready", int'(sample_ready), (m_q.size() < DEPTH) ? 1 : 0);
        chk("underrun", int'(underrun), (e && m_phase == OSR - 1 && m_q.size() == 0) ? 1 : 0);
        chk("fill", int'(fill_level), m_q.size());
        chk("data", int'(data), m_data);
        @(posedge clk);
        rdy = (m_q.size() < DEPTH);
        bnd = e && (m_phase == OSR - 1);
        if (e) begin
            old     = m_total;
            m_total = m_total + m_cur;
            m_data  = ((m_total >> W) != (old >> W)) ? 1 : 0;
            m_phase = (m_phase + 1) % OSR;
        end
        if (bnd && m_q.size() > 0) m_cur = m_q.pop_front();
        if (v && rdy) m_q.push_back(int'(s));
        #1;
    endtask

    task automatic do_reset();
        en           = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        reset_n      = 1'b0;
        #7;
        model_init();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ones;
        int n;

        vecs[0] = '{e: 1'b1, v: 1'b0, s: 8'h00, exp_data: 0, exp_fill: 0};
        vecs[1] = '{e: 1'b1, v: 1'b0, s: 8'h00, exp_data: 1, exp_fill: 0};
        vecs[2] = '{e: 1'b1, v: 1'b1, s: 8'h40, exp_data: 0, exp_fill: 1};
        vecs[3] = '{e: 1'b1, v: 1'b0, s: 8'h00, exp_data: 1, exp_fill: 1};
        vecs[4] = '{e: 1'b0, v: 1'b0, s: 8'h00, exp_data: 1, exp_fill: 1};
        vecs[5] = '{e: 1'b0, v: 1'b1, s: 8'h10, exp_data: 1, exp_fill: 2};
        vecs[6] = '{e: 1'b1, v: 1'b0, s: 8'h00, exp_data: 0, exp_fill: 2};
        vecs[7] = '{e: 1'b1, v: 1'b0, s: 8'h00, exp_data: 1, exp_fill: 2};

        do_reset();
        chk("reset_data", int'(data), 0);
        chk("reset_fill", int'(fill_level), 0);
        chk("reset_ready", int'(sample_ready), 1);
        chk("reset_underrun", int'(underrun), 0);

        foreach (vecs[i]) begin
            cyc(vecs[i].e, vecs[i].v, vecs[i].s);
            chk("vec_data", int'(data), vecs[i].exp_data);
            chk("vec_fill", int'(fill_level), vecs[i].exp_fill);
        end

        // Dense random traffic: FIFO mostly full, backpressure exercised.
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0), 8'($urandom));
        end
        // Sparse random traffic: frequent underruns.
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 99) == 0), 8'($urandom));
        end

        // Extremes: 0x00 frame gives no ones, 0xFF frame from acc=0 gives all ones but the first.
        do_reset();
        cyc(1'b1, 1'b1, 8'h00);
        for (int i = 1; i < OSR; i++) cyc(1'b1, 1'b0, 8'h00);
        ones = 0;
        for (int i = 0; i < OSR; i++) begin
            cyc(1'b1, (i == 0), 8'hFF);
            ones += int'(data);
        end
        chk("zero_frame_ones", ones, 0);
        ones = 0;
        for (int i = 0; i < OSR; i++) begin
            cyc(1'b1, 1'b0, 8'h00);
            ones += int'(data);
        end
        chk("full_frame_ones", ones, OSR - 1);

        // Backpressure: 4 accepted with en=0, 5th waits for the first pop.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'(8'h20 + i));
        chk("bp_fill", int'(fill_level), 4);
        chk("bp_ready", int'(sample_ready), 0);
        cyc(1'b0, 1'b1, 8'h99);
        chk("bp_fill_hold", int'(fill_level), 4);
        n = 0;
        while (sample_ready == 1'b0 && n < 200) begin
            cyc(1'b1, 1'b1, 8'h99);
            n++;
        end
        chk("bp_wait_cycles", n, OSR);
        cyc(1'b1, 1'b1, 8'h99);
        chk("bp_fill_after", int'(fill_level), 4);
        for (int i = 0; i < 3 * OSR; i++) cyc(1'b1, 1'b0, 8'h00);

        // Async reset between edges, mid-frame, with three samples queued.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'(8'h30 + i));
        for (int i = 0; i < 30; i++) cyc(1'b1, 1'b0, 8'h00);
        chk("pre_rst_data", int'(data), 1);
        chk("pre_rst_fill", int'(fill_level), 3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_data", int'(data), 0);
        chk("async_fill", int'(fill_level), 0);
        chk("async_ready", int'(sample_ready), 1);
        model_init();
        en = 1'b0;
        sample_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2 * OSR + 4; i++) cyc(1'b1, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
